// File: rtl/tlul_get_master.sv
// Host-side TL-UL Get master: turns host read commands into A-channel Gets,
// tracks in-flight source IDs and returns D-channel data through one register.
module tlul_get_master #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_id,
    output logic        rsp_err,
    output logic [3:0]  outstanding_cnt,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_param,
    output logic [3:0]  a_size,
    output logic [3:0]  a_mask,
    output logic [31:0] a_address,
    output logic [31:0] a_data,
    output logic [2:0]  a_source,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [2:0]  d_param,
    input  logic [3:0]  d_size,
    input  logic [31:0] d_data,
    input  logic [2:0]  d_source,
    input  logic [1:0]  d_sink
);

    logic [7:0]  r_busy;
    logic [3:0]  r_cnt;
    logic        r_a_valid;
    logic [31:0] r_a_address;
    logic [1:0]  r_a_size;
    logic [3:0]  r_a_mask;
    logic [2:0]  r_a_source;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [2:0]  r_rsp_id;
    logic        r_rsp_err;

    logic        w_legal;
    logic [3:0]  w_mask;
    logic [2:0]  w_free_idx;
    logic        w_any_free;
    logic        w_a_free;
    logic        w_acc_legal;
    logic        w_acc_illegal;
    logic        w_d_hs;
    logic        w_d_busy;
    logic        w_freeing;
    logic [7:0]  w_alloc_vec;
    logic [7:0]  w_free_vec;
    logic        w_unused;

    always_comb begin
        w_legal = 1'b0;
        w_mask  = 4'b0000;
        unique case (req_size)
            2'd0: begin
                w_legal = 1'b1;
                w_mask  = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                w_legal = !req_addr[0];
                w_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                w_legal = (req_addr[1:0] == 2'b00);
                w_mask  = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
                w_mask  = 4'b0000;
            end
        endcase
    end

    // Scan downwards so the lowest free index wins
    always_comb begin
        w_free_idx = 3'd0;
        w_any_free = 1'b0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = 3'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign d_ready   = !r_rsp_valid || rsp_ready;
    assign w_d_hs    = d_valid && d_ready;
    assign w_a_free  = !r_a_valid || a_ready;
    assign req_ready = w_legal ? (w_a_free && w_any_free)
                               : (d_ready && !d_valid);

    assign w_acc_legal   = req_valid && req_ready && w_legal;
    assign w_acc_illegal = req_valid && req_ready && !w_legal;

    // Bits at or above MAX_OUTSTANDING never get set, so range errors fall out here
    assign w_d_busy    = r_busy[d_source];
    assign w_freeing   = w_d_hs && w_d_busy;
    assign w_free_vec  = w_freeing ? (8'd1 << d_source) : 8'd0;
    assign w_alloc_vec = w_acc_legal ? (8'd1 << w_free_idx) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 8'd0;
            r_cnt  <= 4'd0;
        end else begin
            r_busy <= (r_busy | w_alloc_vec) & ~w_free_vec;
            if (w_acc_legal && !w_freeing)
                r_cnt <= r_cnt + 4'd1;
            else if (!w_acc_legal && w_freeing)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid   <= 1'b0;
            r_a_address <= 32'd0;
            r_a_size    <= 2'd0;
            r_a_mask    <= 4'd0;
            r_a_source  <= 3'd0;
        end else if (w_acc_legal) begin
            r_a_valid   <= 1'b1;
            r_a_address <= req_addr;
            r_a_size    <= req_size;
            r_a_mask    <= w_mask;
            r_a_source  <= w_free_idx;
        end else if (a_ready) begin
            r_a_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_id    <= 3'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_d_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= d_data;
            r_rsp_id    <= d_source;
            r_rsp_err   <= (d_opcode != 3'd1) || !w_d_busy;
        end else if (w_acc_illegal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_rsp_id    <= 3'd0;
            r_rsp_err   <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign a_valid         = r_a_valid;
    assign a_opcode        = 3'd4;
    assign a_param         = 3'd0;
    assign a_size          = {2'b00, r_a_size};
    assign a_mask          = r_a_mask;
    assign a_address       = r_a_address;
    assign a_data          = 32'd0;
    assign a_source        = r_a_source;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign rsp_id          = r_rsp_id;
    assign rsp_err         = r_rsp_err;
    assign outstanding_cnt = r_cnt;

    assign w_unused = ^{d_param, d_size, d_sink};

endmodule
